// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem request/ready handshake,
// holds the fetched instruction for the core and redirects the PC on commit.
module instr_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            commit,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      f3,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_fault,
    output logic [31:0]     retired
);

    // state   | meaning
    // S_IDLE  | one cycle after reset before the first fetch
    // S_FETCH | imem_req high at pc, waiting for imem_ready
    // S_HOLD  | instruction latched and presented, waiting for commit
    // S_FAULT | misaligned redirect seen; frozen until reset
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [31:0]     r_retired;
    logic            r_fault;
    logic            r_req;
    logic            r_valid;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_jalr_even;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;

    assign w_pc_plus4  = r_pc + XLEN'(4);
    assign w_jalr_even = jalr_target & {{(XLEN-1){1'b1}}, 1'b0};

    // Reserved select 2'b11 falls back to the sequential PC.
    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pc_sel)
            2'b01:   w_next_pc = br_target;
            2'b10:   w_next_pc = w_jalr_even;
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    assign w_misaligned = |w_next_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_retired <= '0;
            r_fault   <= 1'b0;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_state <= S_HOLD;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (commit) begin
                        r_retired <= r_retired + 32'd1;
                        r_valid   <= 1'b0;
                        // A misaligned target still retires the held instruction.
                        if (w_misaligned) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_req   <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign op          = r_instr[6:0];
    assign f3          = r_instr[14:12];
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_fault = r_fault;
    assign retired     = r_retired;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the single-cycle RISC-V core. It holds the program counter and runs a request/ready handshake with the instruction memory. It presents the latched instruction and its decode fields (Op, F3) to the controller/datapath, and updates the PC on a commit pulse using the controller's 2-bit PC select (sequential, branch/JAL target, JALR target). It also detects misaligned fetch targets and counts retired instructions.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, PC loaded on reset (must be 4-byte aligned)

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; high only in FETCH
- imem_addr  out  XLEN  fetch address, always equals pc
- imem_ready  in  1  memory response valid this cycle; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- commit  in  1  core has finished the held instruction; sampled only in HOLD
- pc_sel  in  2  next-PC select, same encoding as the controller's PcIn: 00 pc+4, 01 br_target, 10 jalr_target, 11 reserved (treated as 00)
- br_target  in  XLEN  pc+imm from datapath (branch/JAL)
- jalr_target  in  XLEN  rs1+imm from ALU
- instr_valid  out  1  instr/op/f3 are valid (HOLD state)
- instr  out  32  latched instruction
- op  out  7  instr[6:0]
- f3  out  3  instr[14:12]
- pc  out  XLEN  address of the held instruction
- pc_plus4  out  XLEN  pc+4, for JAL/JALR link writes
- fetch_fault  out  1  sticky misaligned-target flag
- retired  out  32  count of committed instructions

## Operation
- Four-state FSM: IDLE, FETCH, HOLD, FAULT.
- Reset state: IDLE, pc=RESET_PC, instr=0, retired=0, fetch_fault=0; all outputs deasserted.
- IDLE: one cycle, then FETCH unconditionally.
- FETCH: imem_req=1 and imem_addr=pc.
  - If imem_ready=1, instr<=imem_rdata and the FSM goes to HOLD.
  - Otherwise it stays in FETCH with no timeout.
- HOLD: instr_valid=1; instr, pc and imem_addr are stable.
  - If commit=0, stay in HOLD.
  - If commit=1, compute next PC:
    - pc_sel 00/11: pc+4
    - pc_sel 01: br_target
    - pc_sel 10: jalr_target with bit0 cleared
  - If next[1:0]==0: pc<=next, retired<=retired+1 (wraps modulo 2^32), FSM goes to FETCH.
  - If next[1:0]!=0: pc holds, retired is still incremented, fetch_fault<=1, FSM goes to FAULT.
- FAULT: terminal state; imem_req=0, instr_valid=0, fetch_fault=1. Leaves only on rst.
- Arithmetic: pc+4 is XLEN-bit and wraps at 2^XLEN with no fault; 32'hFFFF_FFFC+4 gives 0.
- imem_ready outside FETCH is ignored; commit outside HOLD is ignored.

## Timing
- Reset is synchronous: rst sampled high at an edge forces the reset state at that edge, from any state.
  - Reset mid-FETCH: the pending response is dropped. A subsequent imem_ready is ignored until the new FETCH.
  - rst and commit high in the same cycle: rst wins, retired=0.
- Fetch latency: imem_ready may be high in the first FETCH cycle (zero-wait memory).
  - Minimum commit-to-instr_valid is 2 edges: commit at edge t, FETCH during cycle t..t+1, HOLD after edge t+1.
  - Each wait cycle of imem_ready adds one cycle.
- Reset release to first instr_valid: minimum 2 cycles (IDLE, FETCH).
- op, f3, pc_plus4 are combinational from registered instr/pc; no extra latency.
- Throughput with zero-wait memory and commit held high: one instruction every 2 cycles.

## Test plan
- Reset/boot: RESET_PC=0, zero-wait memory, mem[0]=32'h0000_2013.
  - Required: imem_req high in the 2nd cycle after reset with addr 0.
  - Required: instr_valid in the 3rd cycle with op=7'h13, f3=3'b010, pc=0, pc_plus4=4.
- Sequential run: commit high with pc_sel=00 for 4 instructions -> pc sequence 0,4,8,12,16; retired=4; instr_valid toggles every cycle.
- Redirects:
  - In HOLD at pc=8, pc_sel=01, br_target=32'h40 -> next fetch addr 32'h40.
  - Then pc_sel=10, jalr_target=32'h101 -> next fetch addr 32'h100 (bit0 cleared).
- Wait states: imem_ready held low 3 cycles in FETCH -> imem_req/imem_addr stable 4 cycles; instr latched only on the ready cycle; retired unchanged.
- Fault: pc_sel=01, br_target=32'h22 -> FAULT next cycle, fetch_fault=1, imem_req=0, pc unchanged, retired incremented. Further commits have no effect; rst clears everything.
- Reset mid-fetch: rst during FETCH with imem_ready low, then imem_ready pulse in IDLE -> pulse ignored; pc=RESET_PC; normal boot sequence follows.
